execute_multicycle: RTL and testbench

Parametrised execute stage for the pipelined processor. It sits between the ID/EX and EX/MEM pipeline registers and performs these functions:
- operand forwarding;
- the ALU, extended with sub, and, or, pass and multiply;
- NZCV flag register and conditional-execution gating.

It adds an iterative shift-add multiplier that stalls the front of the pipeline with a `stall_e` handshake until the product is ready.

---
 rtl/execute_multicycle.sv | 202 ++++++++++++++++++++
 tb/tb_execute_multicycle.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : execute_multicycle
// Purpose : Execute stage with forwarding, ALU, NZCV flags, conditional gating
//           and an optional iterative multiplier (enable with EXECUTE_MUL_EN).
// Revision: 1.0
// ============================================================================
module execute_multicycle #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_e,
   input  logic             flush_e,
   input  logic [2:0]       alu_control_e,
   input  logic             alu_src_e,
   input  logic             mov_src_e,
   input  logic             flag_write_e,
   input  logic             pc_src_e,
   input  logic             reg_write_e,
   input  logic             mem_write_e,
   input  logic             no_write_e,
   input  logic             branch_e,
   input  logic [2:0]       cond_e,
   input  logic [WIDTH-1:0] rd1_e,
   input  logic [WIDTH-1:0] rd2_e,
   input  logic [WIDTH-1:0] ext_e,
   input  logic [WIDTH-1:0] result_w,
   input  logic [WIDTH-1:0] alu_result_m,
   input  logic [1:0]       forward_ae,
   input  logic [1:0]       forward_be,
   output logic [WIDTH-1:0] alu_result_e,
   output logic [WIDTH-1:0] write_data_e,
   output logic             pc_src_m,
   output logic             reg_write_m,
   output logic             mem_write_m,
   output logic             branch_taken_e,
   output logic [3:0]       flags_q,
   output logic             stall_e
);

   localparam logic [2:0] c_OP_SUB  = 3'b001;
   localparam logic [2:0] c_OP_AND  = 3'b010;
   localparam logic [2:0] c_OP_OR   = 3'b011;
   localparam logic [2:0] c_OP_MUL  = 3'b100;
   localparam logic [2:0] c_OP_PASS = 3'b101;
   localparam logic [WIDTH-1:0] c_ZERO = '0;

   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] w_mul_result;
   logic             w_cin;
   logic             w_c;
   logic             w_v;
   logic [3:0]       w_flags_new;
   logic             w_condex;
   logic             w_go;
   logic             w_stall;
   logic [3:0]       r_flags;

   always_comb begin
      case (forward_ae)
         2'b00:   w_fwd_a = rd1_e;
         2'b01:   w_fwd_a = result_w;
         2'b10:   w_fwd_a = alu_result_m;
         default: w_fwd_a = c_ZERO;
      endcase
      case (forward_be)
         2'b00:   w_fwd_b = rd2_e;
         2'b01:   w_fwd_b = result_w;
         2'b10:   w_fwd_b = alu_result_m;
         default: w_fwd_b = c_ZERO;
      endcase
   end

   assign w_a     = mov_src_e ? c_ZERO : w_fwd_a;
   assign w_b     = alu_src_e ? ext_e : w_fwd_b;
   assign w_cin   = (alu_control_e == c_OP_SUB);
   assign w_b_eff = w_cin ? ~w_b : w_b;
   assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

   // Undefined opcodes fall into the default arm and behave as add.
   always_comb begin
      w_result = w_sum[WIDTH-1:0];
      w_c      = 1'b0;
      w_v      = 1'b0;
      case (alu_control_e)
         c_OP_AND:  w_result = w_a & w_b;
         c_OP_OR:   w_result = w_a | w_b;
         c_OP_MUL:  w_result = w_mul_result;
         c_OP_PASS: w_result = w_b;
         default: begin
            w_c = w_sum[WIDTH];
            w_v = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
         end
      endcase
   end

   assign w_flags_new = {w_result[WIDTH-1], (w_result == c_ZERO), w_c, w_v};

   always_comb begin
      case (cond_e)
         3'b000:  w_condex = 1'b1;
         3'b001:  w_condex = r_flags[2];
         3'b010:  w_condex = !r_flags[2];
         3'b011:  w_condex = (r_flags[3] == r_flags[0]);
         3'b100:  w_condex = (r_flags[3] != r_flags[0]);
         3'b101:  w_condex = !r_flags[2] && (r_flags[3] == r_flags[0]);
         3'b110:  w_condex = r_flags[2] || (r_flags[3] != r_flags[0]);
         default: w_condex = 1'b0;
      endcase
   end

   assign w_go = valid_e && w_condex && !flush_e && !w_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= 4'b0000;
      end else if (w_go && flag_write_e) begin
         r_flags <= w_flags_new;
      end
   end

`ifdef EXECUTE_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_count;
   logic             w_accept;

   assign w_accept = valid_e && (alu_control_e == c_OP_MUL) && !flush_e;

   // Operands are latched at accept so forwarding sources may change under a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_mcand  <= c_ZERO;
         r_mplier <= c_ZERO;
         r_acc    <= c_ZERO;
         r_count  <= '0;
      end else if (flush_e) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand  <= w_a;
                  r_mplier <= w_b;
                  r_acc    <= c_ZERO;
                  r_count  <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_mplier[0]) begin
                  r_acc <= r_acc + r_mcand;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + CW'(1);
               if (r_count == CW'(WIDTH - 1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_stall      = ((r_state == S_IDLE) && w_accept) || (r_state == S_BUSY);
   assign w_mul_result = r_acc;
`else
   assign w_stall      = 1'b0;
   assign w_mul_result = c_ZERO;
`endif

   assign alu_result_e   = w_result;
   assign write_data_e   = w_fwd_b;
   assign pc_src_m       = pc_src_e && w_go;
   assign reg_write_m    = reg_write_e && !no_write_e && w_go;
   assign mem_write_m    = mem_write_e && w_go;
   assign branch_taken_e = branch_e && w_go;
   assign flags_q        = r_flags;
   assign stall_e        = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_execute_multicycle.sv
`default_nettype none
// ============================================================================
// Module  : tb_execute_multicycle
// Purpose : Scoreboard bench for execute_multicycle (mul checks need EXECUTE_MUL_EN).
// Revision: 1.0
// ============================================================================
module tb_execute_multicycle;

   localparam int W = 24;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_e, flush_e, alu_src_e, mov_src_e, flag_write_e;
   logic         pc_src_e, reg_write_e, mem_write_e, no_write_e, branch_e;
   logic [2:0]   alu_control_e, cond_e;
   logic [W-1:0] rd1_e, rd2_e, ext_e, result_w, alu_result_m;
   logic [1:0]   forward_ae, forward_be;
   logic [W-1:0] alu_result_e, write_data_e;
   logic         pc_src_m, reg_write_m, mem_write_m, branch_taken_e, stall_e;
   logic [3:0]   flags_q;

   typedef struct {
      string        name;
      logic [W-1:0] res;
      logic [W-1:0] wd;
      logic [3:0]   ctl;
      logic [3:0]   flags;
      int           stalls;
   } exp_t;

   exp_t sbq[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   stall_cnt = 0;

   execute_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
      .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .mov_src_e(mov_src_e),
      .flag_write_e(flag_write_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
      .mem_write_e(mem_write_e), .no_write_e(no_write_e), .branch_e(branch_e),
      .cond_e(cond_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .ext_e(ext_e),
      .result_w(result_w), .alu_result_m(alu_result_m),
      .forward_ae(forward_ae), .forward_be(forward_be),
      .alu_result_e(alu_result_e), .write_data_e(write_data_e),
      .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
      .branch_taken_e(branch_taken_e), .flags_q(flags_q), .stall_e(stall_e)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s.%s got %h expected %h", nm, fld, got, exp);
      end
   endtask

   // Monitor: counts stall cycles, pops and compares when the stage presents a result.
   always @(negedge clk) begin
      if (stall_e === 1'b1) begin
         stall_cnt++;
      end else if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk(e.name, "result", alu_result_e, e.res);
         chk(e.name, "wdata", write_data_e, e.wd);
         chk(e.name, "ctl", W'({pc_src_m, reg_write_m, mem_write_m, branch_taken_e}), W'(e.ctl));
         chk(e.name, "flags", W'(flags_q), W'(e.flags));
         chk(e.name, "stalls", W'(stall_cnt), W'(e.stalls));
         stall_cnt = 0;
      end
   end

   task automatic finish_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   endtask

   task automatic clr();
      valid_e = 0; flush_e = 0; alu_src_e = 0; mov_src_e = 0; flag_write_e = 0;
      pc_src_e = 0; reg_write_e = 0; mem_write_e = 0; no_write_e = 0; branch_e = 0;
      alu_control_e = 3'b000; cond_e = 3'b000; rd1_e = '0; rd2_e = '0; ext_e = '0;
      result_w = '0; alu_result_m = '0; forward_ae = 2'b00; forward_be = 2'b00;
   endtask

   task automatic push(input string nm, input logic [W-1:0] res, input logic [W-1:0] wd,
                       input logic [3:0] ctl, input logic [3:0] fl, input int st);
      exp_t e;
      e.name = nm; e.res = res; e.wd = wd; e.ctl = ctl; e.flags = fl; e.stalls = st;
      sbq.push_back(e);
   endtask

   // Hold inputs until the monitor has seen the result, then advance one edge.
   task automatic settle(input string nm);
      int n;
      n = 0;
      @(negedge clk); #1;
      while (stall_e === 1'b1 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL %s.timeout stall_e still %b expected 0", nm, stall_e);
         finish_run();
      end
      @(posedge clk); #1;
   endtask

   task automatic issue(input string nm, input logic [W-1:0] res, input logic [W-1:0] wd,
                        input logic [3:0] ctl, input logic [3:0] fl, input int st);
      push(nm, res, wd, ctl, fl, st);
      settle(nm);
   endtask

   initial begin
      rst = 1'b1;
      clr();
      #1;
      issue("reset", 24'h0, 24'h0, 4'b0000, 4'b0000, 0);
      rst = 1'b0;

      clr(); valid_e = 1; rd1_e = 24'h7FFFFF; forward_be = 2'b10; alu_result_m = 24'h1;
      flag_write_e = 1; reg_write_e = 1;
      issue("fwd_add", 24'h800000, 24'h1, 4'b0100, 4'b0000, 0);
      clr();
      issue("fwd_add_flags", 24'h0, 24'h0, 4'b0000, 4'b1001, 0);

      clr(); valid_e = 1; alu_control_e = 3'b001; rd1_e = 24'd5; rd2_e = 24'd5; flag_write_e = 1;
      issue("sub_zero", 24'h0, 24'd5, 4'b0000, 4'b1001, 0);

      clr(); valid_e = 1; cond_e = 3'b010; reg_write_e = 1; flag_write_e = 1;
      rd1_e = 24'd1; rd2_e = 24'd2;
      issue("cond_ne_skip", 24'd3, 24'd2, 4'b0000, 4'b0110, 0);

      clr(); valid_e = 1; cond_e = 3'b001; reg_write_e = 1; pc_src_e = 1; mem_write_e = 1;
      branch_e = 1; rd1_e = 24'd1; rd2_e = 24'd2;
      issue("cond_eq_take", 24'd3, 24'd2, 4'b1111, 4'b0110, 0);
      no_write_e = 1;
      issue("no_write", 24'd3, 24'd2, 4'b1011, 4'b0110, 0);

      clr(); valid_e = 1; alu_control_e = 3'b010; forward_ae = 2'b01; result_w = 24'hF0F0F0;
      alu_src_e = 1; ext_e = 24'h0FF0FF; rd2_e = 24'hABCDEF; cond_e = 3'b011;
      mem_write_e = 1; flag_write_e = 1;
      issue("and_ge", 24'h00F0F0, 24'hABCDEF, 4'b0010, 4'b0110, 0);

      clr(); valid_e = 1; alu_control_e = 3'b011; mov_src_e = 1; rd1_e = 24'h123456;
      rd2_e = 24'h800000; flag_write_e = 1; reg_write_e = 1;
      issue("or_mov", 24'h800000, 24'h800000, 4'b0100, 4'b0000, 0);

      clr(); valid_e = 1; alu_control_e = 3'b101; forward_be = 2'b11; rd2_e = 24'd55;
      cond_e = 3'b100; flag_write_e = 1; reg_write_e = 1;
      issue("pass_lt", 24'h0, 24'h0, 4'b0100, 4'b1000, 0);

      clr(); valid_e = 1; rd1_e = 24'hFFFFFF; rd2_e = 24'h1; cond_e = 3'b110;
      flag_write_e = 1; reg_write_e = 1;
      issue("add_carry_le", 24'h0, 24'h1, 4'b0100, 4'b0100, 0);

      clr(); valid_e = 1; alu_control_e = 3'b001; rd1_e = 24'd2; rd2_e = 24'd1;
      cond_e = 3'b101; flag_write_e = 1; reg_write_e = 1;
      issue("gt_skip", 24'd1, 24'd1, 4'b0000, 4'b0110, 0);

      clr(); valid_e = 1; rd1_e = 24'd10; rd2_e = 24'd20; cond_e = 3'b111; reg_write_e = 1;
      flag_write_e = 1;
      issue("nv_skip", 24'd30, 24'd20, 4'b0000, 4'b0110, 0);

      clr(); valid_e = 1; alu_control_e = 3'b110; rd1_e = 24'd10; rd2_e = 24'd20;
      reg_write_e = 1; flag_write_e = 1;
      issue("op110_add", 24'd30, 24'd20, 4'b0100, 4'b0110, 0);

      clr(); valid_e = 1; alu_control_e = 3'b001; rd1_e = 24'd1; rd2_e = 24'd2;
      reg_write_e = 1; flag_write_e = 1;
      issue("sub_borrow", 24'hFFFFFF, 24'd2, 4'b0100, 4'b0000, 0);

      clr(); valid_e = 1; forward_ae = 2'b10; alu_result_m = 24'h000100;
      forward_be = 2'b01; result_w = 24'h000023;
      issue("fwd_mw", 24'h000123, 24'h000023, 4'b0000, 4'b1000, 0);

      clr(); valid_e = 1; flush_e = 1; rd1_e = 24'd1; rd2_e = 24'd1;
      reg_write_e = 1; flag_write_e = 1;
      issue("flush_alu", 24'd2, 24'd1, 4'b0000, 4'b1000, 0);
      clr();
      issue("flush_flags", 24'h0, 24'h0, 4'b0000, 4'b1000, 0);

      rst = 1'b1; clr();
      issue("reset_mid", 24'h0, 24'h0, 4'b0000, 4'b0000, 0);
      rst = 1'b0;

`ifdef EXECUTE_MUL_EN
      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'd1234; rd2_e = 24'd100;
      reg_write_e = 1; flag_write_e = 1;
      issue("mul_1234x100", 24'd123400, 24'd100, 4'b0100, 4'b0000, W + 1);

      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'hFFFFFF; rd2_e = 24'd2;
      reg_write_e = 1; flag_write_e = 1;
      issue("mul_wrap", 24'hFFFFFE, 24'd2, 4'b0100, 4'b0000, W + 1);

      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'd3; alu_src_e = 1; ext_e = 24'd4;
      cond_e = 3'b100; reg_write_e = 1;
      issue("mul_b2b_lt", 24'd12, 24'h0, 4'b0100, 4'b1000, W + 1);

      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'd7; rd2_e = 24'd9;
      reg_write_e = 1; flag_write_e = 1;
      push("mul_flush_busy", 24'h0, 24'h0, 4'b0000, 4'b1000, 6);
      repeat (5) @(posedge clk);
      #1 flush_e = 1;
      @(posedge clk);
      #1 clr();
      settle("mul_flush_busy");

      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'd5; rd2_e = 24'd5;
      reg_write_e = 1; flag_write_e = 1;
      push("mul_reset", 24'h0, 24'h0, 4'b0000, 4'b0000, 3);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1; clr();
      settle("mul_reset");
      rst = 1'b0;

      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'h10; rd2_e = 24'h10;
      reg_write_e = 1;
      issue("mul_after_rst", 24'h100, 24'h10, 4'b0100, 4'b0000, W + 1);
`else
      clr(); valid_e = 1; alu_control_e = 3'b100; rd1_e = 24'd3; rd2_e = 24'd4;
      reg_write_e = 1; flag_write_e = 1;
      issue("mul_off", 24'h0, 24'd4, 4'b0100, 4'b0000, 0);
      clr();
      issue("mul_off_flags", 24'h0, 24'h0, 4'b0000, 4'b0100, 0);
`endif

      for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         n_tests++; n_fail++;
         $display("FAIL %s.unchecked got no output expected one", e.name);
      end
      finish_run();
   end

endmodule
`default_nettype wire
